// File: rtl/tone_seq.sv
// Step sequencer that plays 6-bit note codes from a small RAM as a square wave.
// Each step lasts 2^TEMPO_W cycles; the first 1/16 of every step is silent.
module tone_seq #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int TEMPO_W = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] last,
  output logic          speaker,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_addr
);
  typedef enum logic {IDLE, PLAY} state_e;

  state_e               state_q, state_d;
  logic [TEMPO_W-1:0]   step_q, step_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [8:0]           per_q, per_d;
  logic [7:0]           oct_q, oct_d;
  logic                 spk_q, spk_d;
  logic                 done_q, done_d;
  logic [5:0]           note_q;
  logic [5:0]           mem [DEPTH];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data[5:0];

  // n/12 and n%12 via the upper nibble: 12 = 3*4
  logic [3:0] oct_w, mod_w;
  logic [3:0] semi;
  logic [7:0] reload;
  logic [8:0] clkdiv;
  logic       unused_bits;
  assign oct_w       = note_q[5:2] / 4'd3;
  assign mod_w       = note_q[5:2] % 4'd3;
  assign semi        = {mod_w[1:0], note_q[1:0]};
  assign reload      = 8'hFF >> oct_w[2:0];
  assign unused_bits = ^{wr_data[7:6], oct_w[3], mod_w[3:2]};

  always_comb begin
    case (semi)
      4'd0:    clkdiv = 9'd511;
      4'd1:    clkdiv = 9'd482;
      4'd2:    clkdiv = 9'd455;
      4'd3:    clkdiv = 9'd430;
      4'd4:    clkdiv = 9'd405;
      4'd5:    clkdiv = 9'd383;
      4'd6:    clkdiv = 9'd361;
      4'd7:    clkdiv = 9'd341;
      4'd8:    clkdiv = 9'd322;
      4'd9:    clkdiv = 9'd303;
      4'd10:   clkdiv = 9'd286;
      4'd11:   clkdiv = 9'd270;
      default: clkdiv = 9'd511;
    endcase
  end

  logic step_end, gate_open;
  assign step_end  = &step_q;
  assign gate_open = |step_q[TEMPO_W-1 -: 4];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    addr_d  = addr_q;
    per_d   = per_q;
    oct_d   = oct_q;
    spk_d   = spk_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        spk_d  = 1'b0;
        per_d  = '0;
        oct_d  = '0;
        step_d = '0;
        if (start && !stop) begin
          state_d = PLAY;
          addr_d  = '0;
        end
      end
      PLAY: begin
        step_d = step_q + 1'b1;
        // hold the divider at zero until the new note_q has been read
        if (step_end || step_q == '0) begin
          per_d = '0;
          oct_d = '0;
        end else if (per_q == '0) begin
          per_d = clkdiv;
          oct_d = (oct_q == '0) ? reload : oct_q - 1'b1;
        end else begin
          per_d = per_q - 1'b1;
        end
        if (per_q == '0 && oct_q == '0 && note_q != '0 && gate_open)
          spk_d = ~spk_q;
        if (stop) begin
          state_d = IDLE;
          spk_d   = 1'b0;
        end else if (step_end) begin
          if (addr_q != last) begin
            addr_d = addr_q + 1'b1;
          end else if (loop) begin
            addr_d = '0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            spk_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      addr_q  <= '0;
      per_q   <= '0;
      oct_q   <= '0;
      spk_q   <= 1'b0;
      done_q  <= 1'b0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      per_q   <= per_d;
      oct_q   <= oct_d;
      spk_q   <= spk_d;
      done_q  <= done_d;
      note_q  <= mem[addr_q];
    end
  end

  assign speaker  = spk_q;
  assign busy     = (state_q == PLAY);
  assign done     = done_q;
  assign cur_addr = addr_q;
endmodule
